// File: rtl/ps2_rx_fifo.sv
// ps2_rx_fifo: PS/2 device-to-host receiver (sync + glitch filter, 11-bit deframer,
// E0/F0 prefix decode) feeding a DEPTH-entry event FIFO with a valid/ready output.
// Optional: define PS2_TYPEMATIC_FILTER_EN to suppress repeated make codes (auto-repeat).
module ps2_rx_fifo #(
  parameter int FILTER_LEN     = 8,
  parameter int TIMEOUT_CYCLES = 50000,
  parameter int DEPTH          = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     ps2_clk,
  input  logic                     ps2_dat,
  output logic [7:0]               out_code,
  output logic                     out_ext,
  output logic                     out_break,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [$clog2(DEPTH):0]   fifo_level,
  output logic                     err_parity,
  output logic                     err_frame,
  output logic                     overflow,
  input  logic                     ovf_clr
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;
  localparam int FW = $clog2(FILTER_LEN + 1);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [FW-1:0] FILT_LAST = FW'(FILTER_LEN - 1);
  localparam logic [TW-1:0] TO_LAST   = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [LW-1:0] FULL_LVL  = LW'(DEPTH);

  typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;

  typedef struct packed {
    logic       ext;
    logic       brk;
    logic [7:0] code;
  } entry_t;

  // ---------------- input conditioning ----------------
  logic [1:0]    clk_sync, dat_sync;
  logic          clk_filt, dat_filt, clk_filt_d;
  logic [FW-1:0] clk_cnt, dat_cnt;
  logic          fall, edge_any;

  // two-flop synchronisers; lines idle high so reset to 1
  always_ff @(posedge clk) begin
    if (rst) begin
      clk_sync <= 2'b11;
      dat_sync <= 2'b11;
    end else begin
      clk_sync <= {clk_sync[0], ps2_clk};
      dat_sync <= {dat_sync[0], ps2_dat};
    end
  end

  // glitch filters: a level change needs FILTER_LEN consecutive differing samples
  always_ff @(posedge clk) begin
    if (rst) begin
      clk_filt   <= 1'b1;
      dat_filt   <= 1'b1;
      clk_filt_d <= 1'b1;
      clk_cnt    <= '0;
      dat_cnt    <= '0;
    end else begin
      clk_filt_d <= clk_filt;
      if (clk_sync[1] != clk_filt) begin
        if (clk_cnt == FILT_LAST) begin
          clk_filt <= ~clk_filt;
          clk_cnt  <= '0;
        end else begin
          clk_cnt <= clk_cnt + 1'b1;
        end
      end else begin
        clk_cnt <= '0;
      end
      if (dat_sync[1] != dat_filt) begin
        if (dat_cnt == FILT_LAST) begin
          dat_filt <= ~dat_filt;
          dat_cnt  <= '0;
        end else begin
          dat_cnt <= dat_cnt + 1'b1;
        end
      end else begin
        dat_cnt <= '0;
      end
    end
  end

  assign fall     = clk_filt_d & ~clk_filt;
  assign edge_any = clk_filt_d ^ clk_filt;

  // ---------------- deframer ----------------
  state_t        state;
  logic [2:0]    bit_cnt;
  logic [7:0]    shreg;
  logic          par_ok;
  logic          byte_done;
  logic [TW-1:0] to_cnt;
  logic          timeout;

  assign timeout = (state != IDLE) && !edge_any && (to_cnt == TO_LAST);

  // watchdog: counts clk cycles since the last filtered edge while a frame is open
  always_ff @(posedge clk) begin
    if (rst || edge_any || state == IDLE || timeout) begin
      to_cnt <= '0;
    end else begin
      to_cnt <= to_cnt + 1'b1;
    end
  end

  // frame FSM with registered one-cycle strobes; shreg holds the byte after byte_done
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      bit_cnt    <= '0;
      shreg      <= '0;
      par_ok     <= 1'b0;
      byte_done  <= 1'b0;
      err_parity <= 1'b0;
      err_frame  <= 1'b0;
    end else begin
      byte_done  <= 1'b0;
      err_parity <= 1'b0;
      err_frame  <= 1'b0;
      if (timeout) begin
        state     <= IDLE;
        err_frame <= 1'b1;
      end else if (fall) begin
        case (state)
          IDLE: begin
            if (!dat_filt) begin
              state   <= DATA;
              bit_cnt <= '0;
            end
          end
          DATA: begin
            shreg   <= {dat_filt, shreg[7:1]};
            bit_cnt <= bit_cnt + 1'b1;
            if (bit_cnt == 3'd7) state <= PARITY;
          end
          PARITY: begin
            par_ok <= (^shreg) ^ dat_filt;
            state  <= STOP;
          end
          STOP: begin
            // parity failure reported in preference to a bad stop bit
            if (!par_ok)        err_parity <= 1'b1;
            else if (!dat_filt) err_frame  <= 1'b1;
            else                byte_done  <= 1'b1;
            state <= IDLE;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

  // ---------------- prefix decoder ----------------
  logic ext_pend, brk_pend;
  logic is_e0, is_f0;
  logic push_req;

  assign is_e0 = (shreg == 8'hE0);
  assign is_f0 = (shreg == 8'hF0);

`ifdef PS2_TYPEMATIC_FILTER_EN
  logic [8:0] last_make;
  logic       last_vld;
  logic       make_match;
  assign make_match = last_vld && (last_make == {ext_pend, shreg});
`endif

  // decide whether the completed byte becomes a queued event
  always_comb begin
    push_req = 1'b0;
    if (byte_done && !is_e0 && !is_f0) begin
      push_req = 1'b1;
`ifdef PS2_TYPEMATIC_FILTER_EN
      if (!brk_pend && make_match) push_req = 1'b0;
`endif
    end
  end

  // pending prefix flags (and last-make tracking); errors abandon a prefix sequence
  always_ff @(posedge clk) begin
    if (rst) begin
      ext_pend  <= 1'b0;
      brk_pend  <= 1'b0;
`ifdef PS2_TYPEMATIC_FILTER_EN
      last_make <= '0;
      last_vld  <= 1'b0;
`endif
    end else if (err_parity || err_frame) begin
      ext_pend <= 1'b0;
      brk_pend <= 1'b0;
    end else if (byte_done) begin
      if (is_e0) begin
        ext_pend <= 1'b1;
      end else if (is_f0) begin
        brk_pend <= 1'b1;
      end else begin
        ext_pend <= 1'b0;
        brk_pend <= 1'b0;
`ifdef PS2_TYPEMATIC_FILTER_EN
        if (brk_pend) begin
          if (make_match) last_vld <= 1'b0;
        end else begin
          last_make <= {ext_pend, shreg};
          last_vld  <= 1'b1;
        end
`endif
      end
    end
  end

  // ---------------- event FIFO ----------------
  entry_t        mem [DEPTH];
  logic [AW-1:0] wptr, rptr;
  logic [LW-1:0] level;
  logic          do_push, do_pop, drop;
  entry_t        head;

  assign out_valid  = (level != '0);
  assign do_pop     = out_valid && out_ready;
  assign do_push    = push_req && ((level != FULL_LVL) || do_pop);
  assign drop       = push_req && (level == FULL_LVL) && !do_pop;
  assign head       = mem[rptr];
  assign out_code   = out_valid ? head.code : 8'h00;
  assign out_ext    = out_valid && head.ext;
  assign out_break  = out_valid && head.brk;
  assign fifo_level = level;

  // storage write; contents are only observed through valid entries
  always_ff @(posedge clk) begin
    if (do_push) mem[wptr] <= '{ext: ext_pend, brk: brk_pend, code: shreg};
  end

  // pointers, occupancy and sticky overflow (a new drop beats a clear)
  always_ff @(posedge clk) begin
    if (rst) begin
      wptr     <= '0;
      rptr     <= '0;
      level    <= '0;
      overflow <= 1'b0;
    end else begin
      if (do_push) wptr <= wptr + 1'b1;
      if (do_pop)  rptr <= rptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase
      if (drop)         overflow <= 1'b1;
      else if (ovf_clr) overflow <= 1'b0;
    end
  end

endmodule

// File: tb/tb_ps2_rx_fifo.sv
// tb_ps2_rx_fifo: directed frames through ps2_rx_fifo with hand-computed expectations.
// Runs with FILTER_LEN=8, TIMEOUT_CYCLES=300, DEPTH=4; PS/2 half period is 20 clk cycles.
// Expectations for the auto-repeat sequence follow PS2_TYPEMATIC_FILTER_EN.
module tb_ps2_rx_fifo;

  localparam int FL = 8;
  localparam int TO = 300;
  localparam int DP = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       ps2_clk = 1'b1;
  logic       ps2_dat = 1'b1;
  logic       out_ready = 1'b0;
  logic       ovf_clr = 1'b0;
  logic [7:0] out_code;
  logic       out_ext, out_break, out_valid;
  logic [2:0] fifo_level;
  logic       err_parity, err_frame, overflow;

  int n_cmp = 0;
  int n_bad = 0;
  int par_cnt = 0;
  int frm_cnt = 0;
  logic       rec = 1'b0;
  logic [9:0] popq[$];

  always #5 clk = ~clk;

  ps2_rx_fifo #(.FILTER_LEN(FL), .TIMEOUT_CYCLES(TO), .DEPTH(DP)) dut (
    .clk(clk), .rst(rst), .ps2_clk(ps2_clk), .ps2_dat(ps2_dat),
    .out_code(out_code), .out_ext(out_ext), .out_break(out_break),
    .out_valid(out_valid), .out_ready(out_ready), .fifo_level(fifo_level),
    .err_parity(err_parity), .err_frame(err_frame),
    .overflow(overflow), .ovf_clr(ovf_clr)
  );

  // error pulse counters and popped-event recorder, sampled away from the active edge
  always @(negedge clk) begin
    if (err_parity) par_cnt++;
    if (err_frame) frm_cnt++;
    if (rec && out_valid && out_ready) popq.push_back({out_ext, out_break, out_code});
  end

  task automatic chk(input string tag, input int got, input int exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic send_bit(input logic v);
    @(negedge clk) ps2_dat = v;
    repeat (10) @(negedge clk);
    ps2_clk = 1'b0;
    repeat (20) @(negedge clk);
    ps2_clk = 1'b1;
    repeat (10) @(negedge clk);
  endtask

  task automatic send_frame(input logic [7:0] b, input logic bad_par, input logic bad_stop);
    logic p;
    p = ~(^b) ^ bad_par;
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(b[i]);
    send_bit(p);
    send_bit(~bad_stop);
    ps2_dat = 1'b1;
    repeat (20) @(negedge clk);
  endtask

  task automatic pop_chk(input string tag, input int code, input int ext, input int brk);
    @(negedge clk);
    chk({tag, ".valid"}, out_valid, 1);
    chk({tag, ".code"}, out_code, code);
    chk({tag, ".ext"}, out_ext, ext);
    chk({tag, ".brk"}, out_break, brk);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  initial begin
    int p0, f0, lat;
    logic [9:0] expq[$];

    // reset state
    repeat (5) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("rst.valid", out_valid, 0);
    chk("rst.level", fifo_level, 0);
    chk("rst.ovf", overflow, 0);
    chk("rst.code", out_code, 0);
    chk("rst.errs", err_parity | err_frame, 0);

    // single clean frame, then pop
    send_frame(8'h1C, 1'b0, 1'b0);
    chk("t1.level", fifo_level, 1);
    pop_chk("t1", 8'h1C, 0, 0);
    chk("t1.level_after", fifo_level, 0);

    // extended break, then plain break
    send_frame(8'hE0, 1'b0, 1'b0);
    send_frame(8'hF0, 1'b0, 1'b0);
    send_frame(8'h75, 1'b0, 1'b0);
    chk("t2.level", fifo_level, 1);
    pop_chk("t2a", 8'h75, 1, 1);
    send_frame(8'hF0, 1'b0, 1'b0);
    send_frame(8'h1C, 1'b0, 1'b0);
    chk("t2b.level", fifo_level, 1);
    pop_chk("t2b", 8'h1C, 0, 1);

    // parity error, recovery, bad stop, combined failure
    p0 = par_cnt; f0 = frm_cnt;
    send_frame(8'h1C, 1'b1, 1'b0);
    chk("t3.par_pulses", par_cnt - p0, 1);
    chk("t3.par_level", fifo_level, 0);
    send_frame(8'h1C, 1'b0, 1'b0);
    pop_chk("t3.recover", 8'h1C, 0, 0);
    send_frame(8'h1C, 1'b0, 1'b1);
    chk("t3.frm_pulses", frm_cnt - f0, 1);
    chk("t3.frm_level", fifo_level, 0);
    p0 = par_cnt; f0 = frm_cnt;
    send_frame(8'h1C, 1'b1, 1'b1);
    chk("t3.both_par", par_cnt - p0, 1);
    chk("t3.both_frm", frm_cnt - f0, 0);

    // an error abandons a pending E0 prefix
    send_frame(8'hE0, 1'b0, 1'b0);
    send_frame(8'h1C, 1'b1, 1'b0);
    send_frame(8'h1C, 1'b0, 1'b0);
    pop_chk("t3.prefix_clr", 8'h1C, 0, 0);

    // watchdog: start + 3 data bits, then clock held high
    f0 = frm_cnt; p0 = par_cnt;
    send_bit(1'b0);
    send_bit(1'b1);
    send_bit(1'b0);
    @(negedge clk) ps2_dat = 1'b1;
    repeat (10) @(negedge clk);
    ps2_clk = 1'b0;
    repeat (20) @(negedge clk);
    ps2_clk = 1'b1;
    lat = 0;
    while (frm_cnt == f0 && lat < 2 * TO) begin
      @(negedge clk);
      lat++;
    end
    chk("t4.fired", frm_cnt - f0, 1);
    chk("t4.not_early", int'(lat >= TO), 1);
    chk("t4.not_late", int'(lat <= TO + FL + 6), 1);
    repeat (50) @(negedge clk);
    chk("t4.single_pulse", frm_cnt - f0, 1);
    chk("t4.no_par", par_cnt - p0, 0);
    send_frame(8'h1C, 1'b0, 1'b0);
    chk("t4.level", fifo_level, 1);
    pop_chk("t4.after", 8'h1C, 0, 0);

    // reset mid-frame is silent
    f0 = frm_cnt;
    send_bit(1'b0);
    send_bit(1'b1);
    @(negedge clk) rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (TO + 50) @(negedge clk);
    chk("t5.no_err", frm_cnt - f0, 0);
    chk("t5.level", fifo_level, 0);

    // overflow with DEPTH=4
    send_frame(8'h15, 1'b0, 1'b0);
    send_frame(8'h1D, 1'b0, 1'b0);
    send_frame(8'h24, 1'b0, 1'b0);
    send_frame(8'h2D, 1'b0, 1'b0);
    chk("t6.ovf_before", overflow, 0);
    send_frame(8'h2C, 1'b0, 1'b0);
    chk("t6.level", fifo_level, 4);
    chk("t6.ovf", overflow, 1);
    pop_chk("t6.p0", 8'h15, 0, 0);
    pop_chk("t6.p1", 8'h1D, 0, 0);
    pop_chk("t6.p2", 8'h24, 0, 0);
    pop_chk("t6.p3", 8'h2D, 0, 0);
    chk("t6.empty", fifo_level, 0);
    chk("t6.ovf_sticky", overflow, 1);
    @(negedge clk) ovf_clr = 1'b1;
    @(negedge clk) ovf_clr = 1'b0;
    chk("t6.ovf_clr", overflow, 0);
    out_ready = 1'b1;
    repeat (4) @(negedge clk);
    chk("t6.empty_ready_lvl", fifo_level, 0);
    chk("t6.empty_ready_vld", out_valid, 0);

    // auto-repeat sequence, drained continuously
    rec = 1'b1;
    send_frame(8'h1C, 1'b0, 1'b0);
    send_frame(8'h1C, 1'b0, 1'b0);
    send_frame(8'h1C, 1'b0, 1'b0);
    send_frame(8'hF0, 1'b0, 1'b0);
    send_frame(8'h1C, 1'b0, 1'b0);
    send_frame(8'h1C, 1'b0, 1'b0);
    repeat (10) @(negedge clk);
    rec = 1'b0;
    out_ready = 1'b0;
`ifdef PS2_TYPEMATIC_FILTER_EN
    expq = '{10'h01C, 10'h11C, 10'h01C};
`else
    expq = '{10'h01C, 10'h01C, 10'h01C, 10'h11C, 10'h01C};
`endif
    chk("t7.count", popq.size(), expq.size());
    for (int i = 0; i < expq.size(); i++) begin
      if (i < popq.size()) chk($sformatf("t7.ev%0d", i), popq[i], expq[i]);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
